// File: rtl/serial_shifter.sv
// serial_shifter: iterative one-bit-per-cycle shift unit feeding the register
// file write port. A result is presented for exactly one cycle in DONE.
// Optional feature: define SERIAL_SHIFTER_ROTATE_EN to turn op 11 into a
// rotate-right. Otherwise op 11 is reserved: it completes without a write.
module serial_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt,
  input  logic [4:0]       dest,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [4:0]       wad,
  output logic [WIDTH-1:0] wd,
  output logic             write_reg
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [SHW-1:0]   cnt;
  logic [1:0]       op_q;
  logic [4:0]       dest_q;
  logic             accept;
  logic             skip_shift;

  // A request is taken whenever the unit is not mid-shift (IDLE or DONE).
  assign accept = start && (state != ST_SHIFT);

  // Zero-length shifts (and the reserved op) complete in a single cycle.
`ifdef SERIAL_SHIFTER_ROTATE_EN
  assign skip_shift = (shamt == '0);
`else
  assign skip_shift = (shamt == '0) || (op == OP_ROR);
`endif

  // Single-bit step of the accumulator for the latched operation.
  always_comb begin
    acc_next = acc;
    case (op_q)
      OP_SLL:  acc_next = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_next = {1'b0, acc[WIDTH-1:1]};
      OP_SRA:  acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: begin
`ifdef SERIAL_SHIFTER_ROTATE_EN
        acc_next = {acc[0], acc[WIDTH-1:1]};
`endif
      end
    endcase
  end

  // Control FSM and datapath registers; reset drops any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      acc    <= '0;
      cnt    <= '0;
      op_q   <= '0;
      dest_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            acc    <= operand;
            cnt    <= shamt;
            op_q   <= op;
            dest_q <= dest;
            state  <= skip_shift ? ST_DONE : ST_SHIFT;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only; write-back fields zero outside DONE.
  assign ready = (state == ST_IDLE) || (state == ST_DONE);
  assign busy  = (state == ST_SHIFT);
  assign done  = (state == ST_DONE);
  assign wd    = done ? acc : '0;
  assign wad   = done ? dest_q : '0;
`ifdef SERIAL_SHIFTER_ROTATE_EN
  assign write_reg = done;
`else
  assign write_reg = done && (op_q != OP_ROR);
`endif

endmodule
